// File: rtl/sar_adc_pkg.sv
// Shared types and sizing helpers for the SAR ADC controller and its sub-blocks.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_BIT_REQ,
    ST_BIT_ACK,
    ST_BIT_REL,
    ST_ACC,
    ST_DONE
  } sar_state_t;

  localparam int SAR_N_DEF   = 12;
  localparam int SAR_NCH_DEF = 4;

  // Width of a counter that runs 0 .. max(a,b)-1.
  function automatic int sar_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int sar_ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_if.sv
// Pin bundle between the controller (master) and the analog SAR macro (slave).
interface sar_adc_if #(
  parameter int N  = 12,
  parameter int CW = 2
);
  logic [CW-1:0] ms_adc_ch;
  logic          ms_adc_sample;
  logic          ms_adc_clk;
  logic [N-1:0]  ms_adc_dac;
  logic          ms_adc_rdy;
  logic          ms_adc_cmp;

  modport master (
    output ms_adc_ch, ms_adc_sample, ms_adc_clk, ms_adc_dac,
    input  ms_adc_rdy, ms_adc_cmp
  );

  modport slave (
    input  ms_adc_ch, ms_adc_sample, ms_adc_clk, ms_adc_dac,
    output ms_adc_rdy, ms_adc_cmp
  );
endinterface

// File: rtl/sar_bit_seq.sv
// N-bit successive-approximation register with a trial-bit pointer (load / step / keep).
module sar_bit_seq #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic         step,
  input  logic         cmp,
  output logic [N-1:0] trial,
  output logic [N-1:0] kept,
  output logic         fin
);
  localparam int RW = $clog2(N + 1);

  logic [N-1:0]  sar_q, sar_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [N-1:0]  bit_mask;

  // rem_q counts bits still to resolve; the trial bit is rem_q-1.
  always_comb begin
    bit_mask = '0;
    if (rem_q != '0) bit_mask = N'(1) << (rem_q - RW'(1));
    sar_d = sar_q;
    rem_d = rem_q;
    if (load) begin
      sar_d = '0;
      rem_d = RW'(N);
    end else if (step && (rem_q != '0)) begin
      sar_d = cmp ? (sar_q | bit_mask) : sar_q;
      rem_d = rem_q - RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sar_q <= '0;
      rem_q <= '0;
    end else begin
      sar_q <= sar_d;
      rem_q <= rem_d;
    end
  end

  assign trial = sar_q | bit_mask;
  assign kept  = sar_q;
  assign fin   = (rem_q == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sampling, bitwise 4-phase comparator handshake, averaging and channel scan.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int  N           = SAR_N_DEF,
  parameter int  NCH         = SAR_NCH_DEF,
  parameter int  SAMPLE_CYC  = 8,
  parameter int  AVG_LOG2    = 0,
  parameter int  RDY_TIMEOUT = 16,
  localparam int CW          = sar_ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             scan,
  input  logic             cont,
  input  logic [CW-1:0]    ch_sel,
  input  logic [NCH-1:0]   ch_mask,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N-1:0]     data,
  output logic [CW-1:0]    ch_out,
  sar_adc_if.master        adc
);
  localparam int CNT_W = sar_cnt_w(SAMPLE_CYC, RDY_TIMEOUT);
  localparam int VW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW    = N + AVG_LOG2;
  localparam logic [VW-1:0] CONV_LAST = VW'((1 << AVG_LOG2) - 1);

  sar_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VW-1:0]  conv_q, conv_d;
  logic [AW-1:0]  acc_q, acc_d, acc_sum;
  logic [NCH-1:0] mask_q, mask_d, mask_new;
  logic [CW-1:0]  ch_q, ch_d, sel_idx;
  logic           err_q, err_d;
  logic [N-1:0]   data_q, data_d;
  logic [CW-1:0]  ch_out_q, ch_out_d;
  logic [CW:0]    nx;
  logic           seq_load, seq_step, timeout;
  logic           sample_o, mclk_o;
  logic [N-1:0]   dac_o, trial, kept;
  logic           fin;

  // Lowest set bit of m strictly above cur; MSB of the result flags "found".
  function automatic logic [CW:0] next_ch(input logic [NCH-1:0] m, input int cur);
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if ((i > cur) && m[i]) r = {1'b1, CW'(i)};
    return r;
  endfunction

  sar_bit_seq #(.N(N)) u_seq (
    .clk   (clk),
    .rstb  (rstb),
    .load  (seq_load),
    .step  (seq_step),
    .cmp   (adc.ms_adc_cmp),
    .trial (trial),
    .kept  (kept),
    .fin   (fin)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    conv_d   = conv_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    err_d    = err_q;
    data_d   = data_q;
    ch_out_d = ch_out_q;
    seq_load = 1'b0;
    seq_step = 1'b0;
    timeout  = 1'b0;
    sample_o = 1'b0;
    mclk_o   = 1'b0;
    dac_o    = '0;
    done     = 1'b0;
    sel_idx  = CW'(int'(ch_sel) % NCH);
    mask_new = scan ? ch_mask : (NCH'(1) << sel_idx);
    acc_sum  = acc_q + AW'(kept);
    nx       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          mask_d = mask_new;
          if (mask_new == '0) begin
            err_d = 1'b1;
          end else begin
            nx      = next_ch(mask_new, -1);
            ch_d    = nx[CW-1:0];
            cnt_d   = '0;
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        sample_o = 1'b1;
        seq_load = 1'b1;
        if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_BIT_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BIT_REQ: begin
        mclk_o  = 1'b1;
        dac_o   = trial;
        cnt_d   = '0;
        state_d = ST_BIT_ACK;
      end
      ST_BIT_ACK: begin
        mclk_o = 1'b1;
        dac_o  = trial;
        if (adc.ms_adc_rdy) begin
          seq_step = 1'b1;
          cnt_d    = '0;
          state_d  = ST_BIT_REL;
        end else if (cnt_q == CNT_W'(RDY_TIMEOUT - 1)) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BIT_REL: begin
        dac_o = kept;
        if (!adc.ms_adc_rdy) begin
          cnt_d   = '0;
          state_d = fin ? ST_ACC : ST_BIT_REQ;
        end else if (cnt_q == CNT_W'(RDY_TIMEOUT - 1)) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACC: begin
        acc_d = acc_sum;
        cnt_d = '0;
        if (conv_q == CONV_LAST) begin
          conv_d   = '0;
          data_d   = N'(acc_sum >> AVG_LOG2);
          ch_out_d = ch_q;
          state_d  = ST_DONE;
        end else begin
          conv_d  = conv_q + VW'(1);
          state_d = ST_SAMPLE;
        end
      end
      ST_DONE: begin
        done  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        nx    = next_ch(mask_q, int'(ch_q));
        if (nx[CW]) begin
          ch_d    = nx[CW-1:0];
          state_d = ST_SAMPLE;
        end else if (cont) begin
          nx      = next_ch(mask_q, -1);
          ch_d    = nx[CW-1:0];
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An unanswered handshake abandons the whole job.
    if (timeout) begin
      err_d   = 1'b1;
      acc_d   = '0;
      conv_d  = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      conv_q   <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
      ch_q     <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      ch_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      conv_q   <= conv_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      err_q    <= err_d;
      data_q   <= data_d;
      ch_out_q <= ch_out_d;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign err               = err_q;
  assign data              = data_q;
  assign ch_out            = ch_out_q;
  assign adc.ms_adc_ch     = (state_q != ST_IDLE) ? ch_q : '0;
  assign adc.ms_adc_sample = sample_o;
  assign adc.ms_adc_clk    = mclk_o;
  assign adc.ms_adc_dac    = dac_o;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: behavioural comparator macro plus a done-driven scoreboard.
module tb_sar_adc_ctrl;
  localparam int N = 12, NCH = 4, SCYC = 8, AVG = 2, TMO = 16;

  logic       clk, rstb, start, scan, cont;
  logic [1:0] ch_sel;
  logic [3:0] ch_mask;
  logic       busy, done, err;
  logic [N-1:0] data;
  logic [1:0] ch_out;

  sar_adc_if #(.N(N), .CW(2)) bus ();

  sar_adc_ctrl #(.N(N), .NCH(NCH), .SAMPLE_CYC(SCYC), .AVG_LOG2(AVG), .RDY_TIMEOUT(TMO)) dut (
    .clk(clk), .rstb(rstb), .start(start), .scan(scan), .cont(cont),
    .ch_sel(ch_sel), .ch_mask(ch_mask), .busy(busy), .done(done), .err(err),
    .data(data), .ch_out(ch_out), .adc(bus)
  );

  typedef struct { int ch; int code; } exp_t;
  exp_t sb[$];

  int  n_tests = 0, n_fail = 0;
  int  n_done = 0, n_phase = 0, samp_cnt = 0;
  real vin_tab[4];
  real vin_conv[4];
  bit  conv_mode = 0, dly_en = 0, stuck_en = 0;
  logic rdy_q = 1'b0;
  logic stuck_hit;
  real v_now;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator macro: keeps the trial bit when VIN*2^N >= DAC code.
  always_comb begin
    v_now = conv_mode ? vin_conv[(samp_cnt + 3) % 4] : vin_tab[bus.ms_adc_ch];
    stuck_hit = stuck_en && bus.ms_adc_dac[5] && (bus.ms_adc_dac[4:0] == 5'd0);
    bus.ms_adc_cmp = (real'(bus.ms_adc_dac) <= v_now * 4096.0);
    bus.ms_adc_rdy = stuck_hit ? 1'b0 : (dly_en ? rdy_q : bus.ms_adc_clk);
  end

  initial forever begin
    @(posedge clk);
    rdy_q <= bus.ms_adc_clk;
  end

  // Monitor: scoreboard pop on done, sample phase length, DAC stability while ms_adc_clk high.
  initial begin
    logic prev_s, prev_c, dac_bad, s_bad;
    logic [N-1:0] prev_dac;
    int run_len;
    exp_t e;
    prev_s = 0; prev_c = 0; dac_bad = 0; s_bad = 0; run_len = 0; prev_dac = '0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        prev_s = 0; prev_c = 0; dac_bad = 0; s_bad = 0; run_len = 0;
      end else begin
        if (bus.ms_adc_sample && !prev_s) samp_cnt++;
        if (bus.ms_adc_sample) begin
          run_len++;
          if (bus.ms_adc_dac != '0) s_bad = 1;
        end
        if (!bus.ms_adc_sample && prev_s) begin
          n_phase++;
          n_tests++;
          if (run_len != SCYC || s_bad) begin
            n_fail++;
            $display("FAIL sample_phase: len %0d dac_nonzero %0d, want len %0d dac_nonzero 0", run_len, s_bad, SCYC);
          end
          run_len = 0; s_bad = 0;
        end
        if (bus.ms_adc_clk && prev_c && bus.ms_adc_dac != prev_dac) dac_bad = 1;
        if (!bus.ms_adc_clk && prev_c) begin
          n_tests++;
          if (dac_bad) begin
            n_fail++;
            $display("FAIL dac_stable: dac changed while ms_adc_clk high, want stable");
          end
          dac_bad = 0;
        end
        if (done) begin
          n_done++;
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: ch %0d data %0d, want no done", ch_out, data);
          end else begin
            e = sb.pop_front();
            if (data !== N'(e.code) || ch_out !== 2'(e.ch)) begin
              n_fail++;
              $display("FAIL result: ch %0d data %0d, want ch %0d data %0d", ch_out, data, e.ch, e.code);
            end
          end
        end
        prev_s = bus.ms_adc_sample;
        prev_c = bus.ms_adc_clk;
        prev_dac = bus.ms_adc_dac;
      end
    end
  end

  task automatic pulse_start(input logic sc, input logic co, input logic [1:0] cs, input logic [3:0] cm);
    @(negedge clk);
    scan = sc; cont = co; ch_sel = cs; ch_mask = cm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, want 0", max_cyc);
    end
  endtask

  function automatic int code_of(input real v);
    return int'($floor(v * 4096.0));
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, err, data, ch_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", {busy, done, err, data, ch_out});
    end
    n_tests++;
    if ({bus.ms_adc_ch, bus.ms_adc_sample, bus.ms_adc_clk, bus.ms_adc_dac} !== '0) begin
      n_fail++;
      $display("FAIL reset_macro_pins: got %h, want 0", {bus.ms_adc_ch, bus.ms_adc_sample, bus.ms_adc_clk, bus.ms_adc_dac});
    end
    rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    vin_tab[2] = 0.6;
    n_done = 0; n_phase = 0;
    sb.push_back('{2, 2457});
    pulse_start(1'b0, 1'b0, 2'd2, 4'h0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: busy %0b, want 1", busy);
    end
    wait_idle(2000);
    n_tests++;
    if (n_done != 1 || n_phase != 4 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_counts: done %0d phases %0d err %0b, want 1 4 0", n_done, n_phase, err);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (data !== 12'd2457 || ch_out !== 2'd2) begin
      n_fail++;
      $display("FAIL single_hold: data %0d ch %0d, want 2457 2", data, ch_out);
    end
  endtask

  task automatic test_avg();
    int sum = 0;
    vin_tab[1] = 0.25;
    n_done = 0; n_phase = 0;
    sb.push_back('{1, 1024});
    pulse_start(1'b0, 1'b0, 2'd1, 4'h0);
    wait_idle(2000);
    n_tests++;
    if (n_phase != 4) begin
      n_fail++;
      $display("FAIL avg_phases: %0d sample phases, want 4", n_phase);
    end
    vin_conv[0] = 0.1; vin_conv[1] = 0.2; vin_conv[2] = 0.3; vin_conv[3] = 0.45;
    for (int i = 0; i < 4; i++) sum += code_of(vin_conv[i]);
    samp_cnt = 0;
    conv_mode = 1;
    sb.push_back('{1, sum / 4});
    pulse_start(1'b0, 1'b0, 2'd1, 4'h0);
    wait_idle(2000);
    conv_mode = 0;
    n_tests++;
    if (n_done != 2) begin
      n_fail++;
      $display("FAIL avg_done_count: %0d, want 2", n_done);
    end
  endtask

  task automatic test_scan();
    vin_tab[1] = 0.3; vin_tab[3] = 0.9;
    dly_en = 1;
    n_done = 0;
    sb.push_back('{1, code_of(0.3)});
    sb.push_back('{3, code_of(0.9)});
    pulse_start(1'b1, 1'b0, 2'd0, 4'b1010);
    wait_idle(4000);
    dly_en = 0;
    n_tests++;
    if (n_done != 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL scan_done_count: done %0d pending %0d, want 2 0", n_done, sb.size());
    end
  endtask

  task automatic test_timeout();
    int k = 0, hold = 0;
    vin_tab[0] = 0.7;
    stuck_en = 1;
    n_done = 0;
    pulse_start(1'b0, 1'b0, 2'd0, 4'h0);
    while (!err && k < 3000) begin
      @(negedge clk);
      if (bus.ms_adc_clk && stuck_hit) hold++;
      k++;
    end
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: err %0b after %0d cycles, want 1", err, k);
    end
    n_tests++;
    if (hold != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_wait: ms_adc_clk high %0d cycles at bit 5, want %0d", hold, TMO + 1);
    end
    n_tests++;
    if ({busy, bus.ms_adc_ch, bus.ms_adc_sample, bus.ms_adc_clk, bus.ms_adc_dac} !== '0) begin
      n_fail++;
      $display("FAIL timeout_quiet: got %h, want 0", {busy, bus.ms_adc_ch, bus.ms_adc_sample, bus.ms_adc_clk, bus.ms_adc_dac});
    end
    repeat (5) @(negedge clk);
    stuck_en = 0;
    n_tests++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL timeout_no_done: %0d, want 0", n_done);
    end
    sb.push_back('{0, code_of(0.7)});
    pulse_start(1'b0, 1'b0, 2'd0, 4'h0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err %0b, want 0", err);
    end
    wait_idle(2000);
    n_tests++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL timeout_recover: done %0d, want 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, gap = 0;
    bit poked = 0;
    vin_tab[0] = 0.5; vin_tab[3] = 0.1;
    n_done = 0;
    for (int i = 0; i < 4; i++) sb.push_back('{0, 2048});
    pulse_start(1'b0, 1'b1, 2'd0, 4'h0);
    while (n_done < 3 && k < 5000) begin
      @(negedge clk);
      if (!busy) gap++;
      k++;
      if (n_done == 1 && !poked) begin
        poked = 1;
        pulse_start(1'b0, 1'b1, 2'd3, 4'h0);
      end
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (gap != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_busy: idle cycles %0d busy %0b, want 0 1", gap, busy);
    end
    cont = 1'b0;
    wait_idle(3000);
    n_tests++;
    if (n_done != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL cont_jobs: done %0d pending %0d, want 4 0", n_done, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int k = 0, hold = 0;
    vin_tab[2] = 0.6;
    stuck_en = 1;
    n_done = 0;
    pulse_start(1'b0, 1'b0, 2'd2, 4'h0);
    while (hold < 3 && k < 3000) begin
      @(negedge clk);
      if (bus.ms_adc_clk && stuck_hit) hold++;
      k++;
    end
    #2 rstb = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, err, data, ch_out, bus.ms_adc_ch, bus.ms_adc_sample, bus.ms_adc_clk, bus.ms_adc_dac} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h, want 0",
               {busy, done, err, data, ch_out, bus.ms_adc_ch, bus.ms_adc_sample, bus.ms_adc_clk, bus.ms_adc_dac});
    end
    stuck_en = 0;
    @(negedge clk);
    rstb = 1'b1;
    sb.push_back('{2, 2457});
    pulse_start(1'b0, 1'b0, 2'd2, 4'h0);
    wait_idle(2000);
    n_tests++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL reset_recover: done %0d, want 1", n_done);
    end
  endtask

  task automatic test_empty_mask();
    int busy_seen = 0;
    n_done = 0;
    pulse_start(1'b1, 1'b0, 2'd0, 4'b0000);
    repeat (5) begin
      if (busy) busy_seen++;
      @(negedge clk);
    end
    n_tests++;
    if (err !== 1'b1 || busy_seen != 0 || n_done != 0) begin
      n_fail++;
      $display("FAIL empty_mask: err %0b busy cycles %0d done %0d, want 1 0 0", err, busy_seen, n_done);
    end
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; scan = 1'b0; cont = 1'b0; ch_sel = '0; ch_mask = '0;
    for (int i = 0; i < 4; i++) begin
      vin_tab[i] = 0.0;
      vin_conv[i] = 0.0;
    end
    test_reset();
    test_single();
    test_avg();
    test_scan();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_empty_mask();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
